// File: rtl/instructions.sv
// instructions: opcode field codes and controller state type for the 12-bit CPU
package instructions;
  localparam logic [2:0] T_SYS = 3'd0;
  localparam logic [2:0] T_ALU = 3'd1;
  localparam logic [2:0] T_MOV = 3'd2;
  localparam logic [2:0] T_JMP = 3'd3;
  localparam logic [2:0] T_LDI = 3'd4;
  localparam logic [2:0] SYS_NOP = 3'd0;
  localparam logic [2:0] SYS_HALT = 3'd1;
  localparam logic [2:0] JMP_AL = 3'd0;
  localparam logic [2:0] JMP_Z = 3'd1;
  localparam logic [2:0] JMP_NZ = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALTED} state_t;
endpackage

// File: rtl/decoder.sv
// decoder: splits a 12-bit opcode into type, sub, a and b fields
module decoder (
  input  logic [11:0] ir,
  output logic [2:0]  typ,
  output logic [2:0]  sub,
  output logic [2:0]  a,
  output logic [2:0]  b
);
  assign {typ, sub, a, b} = ir;
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute sequencer for the 12-bit-opcode CPU
module cpu_control_fsm
  import instructions::*;
#(
  parameter int PC_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [11:0]       imem_rdata,
  output logic [2:0]        rf_raddr_a,
  output logic [2:0]        rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [PC_W-1:0]   pc,
  output logic              zero_flag,
  output logic              halted,
  output logic              illegal
);
  state_t state;
  logic [11:0] ir;
  logic [2:0] typ, sub;
  logic bad, stop, taken, wr;
  logic [PC_W-1:0] next_pc;
  logic [DATA_W-1:0] wdata;
  logic unused_rdata_a;
  decoder u_dec (.ir(ir), .typ(typ), .sub(sub), .a(rf_raddr_a), .b(rf_raddr_b));
  assign alu_op = sub;
  assign imem_addr = pc;
  assign unused_rdata_a = ^rf_rdata_a;
  // classify the held instruction: legality, halt, jump outcome, write data and next pc
  always_comb begin
    taken = sub == JMP_AL || (sub == JMP_Z && zero_flag) || (sub == JMP_NZ && !zero_flag);
    bad = (typ == T_SYS && sub != SYS_NOP && sub != SYS_HALT) || (typ == T_JMP && sub > JMP_NZ) || typ > T_LDI;
    stop = bad || (typ == T_SYS && sub == SYS_HALT);
    wr = typ == T_ALU || typ == T_MOV || typ == T_LDI;
    wdata = typ == T_ALU ? alu_result : typ == T_MOV ? rf_rdata_b : DATA_W'({sub, rf_raddr_b});
    next_pc = typ == T_JMP && taken ? rf_rdata_b[PC_W-1:0] : pc + PC_W'(1);
  end
  // sequencer; write strobe is set on entry to EXECUTE so it is high only during EXECUTE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= '0;
      ir <= '0;
      zero_flag <= 1'b0;
      illegal <= 1'b0;
      halted <= 1'b0;
      imem_req <= 1'b0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE: if (run) begin
          state <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: if (imem_ready) begin
          ir <= imem_rdata;
          imem_req <= 1'b0;
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          rf_we <= wr;
          rf_waddr <= rf_raddr_a;
          rf_wdata <= wdata;
        end
        S_EXECUTE: begin
          if (bad) illegal <= 1'b1;
          if (typ == T_ALU) zero_flag <= alu_result == '0;
          if (stop) begin
            state <= S_HALTED;
            halted <= 1'b1;
          end else begin
            pc <= next_pc;
            state <= run ? S_FETCH : S_IDLE;
            imem_req <= run;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
